debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flops in each input synchroniser (>=1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 32: consecutive disagreeing samples required to flip a channel (>=1).
REQ-004 SHALL have parameter LONG_CYCLES, default 0: cycles out must be held high before long_press pulses; 0 disables long-press.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port in  input  CHANNELS: raw, asynchronous, bouncy inputs; bit i is channel i.
REQ-008 SHALL have port out  output  CHANNELS: debounced level per channel, registered.
REQ-009 SHALL have port rise  output  CHANNELS: one-cycle pulse per channel on a debounced 0->1 transition.
REQ-010 SHALL have port fall  output  CHANNELS: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-011 SHALL have port long_press  output  CHANNELS: one-cycle pulse per channel when out has been held high LONG_CYCLES cycles.

Function
REQ-012 Each channel SHALL be fully independent; no shared counters or arbitration between channels.
REQ-013 Each channel SHALL pass in[i] through a SYNC_STAGES-deep flip-flop chain; its last stage is sync[i].
REQ-014 Each channel SHALL hold a stability counter of width clog2(STABLE_CYCLES+1), minimum 1 bit.
REQ-015 Per edge, if sync[i]==out[i], the stability counter SHALL clear to 0.
REQ-016 Per edge, if sync[i]!=out[i] and counter<STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 Per edge, if sync[i]!=out[i] and counter==STABLE_CYCLES-1, out[i] SHALL take sync[i] and the counter SHALL clear to 0.
REQ-018 Any single sample with sync[i]==out[i] SHALL restart the count; a glitch shorter than STABLE_CYCLES samples SHALL never reach out.
REQ-019 Latency: counting the first edge that samples a new stable value of in[i] as edge 1, out[i] SHALL change on edge SYNC_STAGES+STABLE_CYCLES.
REQ-020 rise[i] SHALL be 1 for exactly the one cycle following the edge where out[i] goes 0->1, and 0 otherwise.
REQ-021 fall[i] SHALL be 1 for exactly the one cycle following the edge where out[i] goes 1->0, and 0 otherwise.
REQ-022 rise[i] and fall[i] SHALL never be 1 in the same cycle.
REQ-023 With STABLE_CYCLES=1, out[i] SHALL follow sync[i] with one edge of delay, pulsing on every change.
REQ-024 Each channel SHALL hold a hold counter of width clog2(LONG_CYCLES+1), minimum 1 bit.
REQ-025 The hold counter SHALL clear on any edge where out[i] is 0 or out[i] goes 0->1.
REQ-026 While out[i] is 1, the hold counter SHALL increment per edge and saturate at LONG_CYCLES, with no wrap-around.
REQ-027 long_press[i] SHALL pulse for one cycle when the hold counter reaches LONG_CYCLES, exactly LONG_CYCLES edges after the edge that raised out[i].
REQ-028 long_press[i] SHALL pulse at most once per high period.
REQ-029 A fall before LONG_CYCLES elapses SHALL suppress long_press for that press.
REQ-030 With LONG_CYCLES=0, long_press SHALL be constant 0 and the hold counter logic SHALL be absent.

Reset
REQ-031 While rst is 1 at an edge, all synchroniser flops, out, rise, fall, long_press and all counters SHALL clear to 0.
REQ-032 rst SHALL take priority over every other update in the same cycle, including a channel about to flip.
REQ-033 If in[i] is 1 when rst deasserts, out[i] SHALL rise, with a rise pulse, SYNC_STAGES+STABLE_CYCLES edges later.
REQ-034 Reset asserted mid-count or mid-hold SHALL discard the progress; no pulse SHALL be emitted for the interrupted event.

Verification
(Bench parameters: CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, LONG_CYCLES=10.)
REQ-035 Clean step: in[0] 0->1 sampled at edge 1 -> out[0]=1 after edge 6; rise[0]=1 that cycle only; other channels stay 0.
REQ-036 Bounce: in[1] toggles 1,0,1,0 on successive cycles, then holds 1 -> out[1] stays 0 through the bounce and rises 6 edges after the final 0->1.
REQ-037 Glitch: in[2] held 1 and out[2]=1, then a 3-cycle 0 pulse -> out[2] stays 1 and fall[2] never asserts.
REQ-038 Long press: in[3] held 1 -> rise[3] pulses, then long_press[3] pulses 10 edges later exactly once; release after 40 cycles -> fall[3] pulses and no second long_press.
REQ-039 Short press: in[3] held high 8 cycles after its rise -> rise and fall each pulse once and long_press[3] stays 0.
REQ-040 Reset mid-count: in[0]=1 with its count at 2, rst pulsed for one cycle -> all outputs 0; out[0] rises 6 edges after rst deasserts.

Source files
------------

// File: rtl/debounce_bank.sv
// Bank of independent input debouncers.
// Each channel synchronises its raw input, requires STABLE_CYCLES consecutive
// disagreeing samples before the registered level flips, and emits one-cycle
// rise/fall pulses. An optional hold timer pulses long_press once per high period.
module debounce_bank #(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 32,
  parameter int unsigned LONG_CYCLES   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int unsigned CntW =
      ($clog2(STABLE_CYCLES + 1) > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  sync_w;
  logic [CHANNELS-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  out_q, out_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;

  // Synchroniser chain: stage 0 samples the raw input, last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Stability filter: any agreeing sample restarts the count; the last
  // disagreeing sample flips the level. Edge pulses derive from the flip.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_w[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        out_d[i] = sync_w[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // Filter state and registered outputs; reset wins over a pending flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    logic [CHANNELS-1:0][HoldW-1:0] hold_q, hold_d;
    logic [CHANNELS-1:0]            lp_q, lp_d;

    // Hold timer: counts edges spent high, saturating so the pulse fires once.
    // A falling edge on the same cycle as expiry suppresses the pulse.
    always_comb begin
      hold_d = hold_q;
      lp_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!out_q[i]) begin
          hold_d[i] = '0;
        end else if (hold_q[i] != HoldMax) begin
          hold_d[i] = hold_q[i] + HoldW'(1);
        end
        lp_d[i] = out_q[i] & out_d[i] & (hold_q[i] == HoldLast);
      end
    end

    // Hold timer state and long-press pulse register.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        lp_q   <= '0;
      end else begin
        hold_q <= hold_d;
        lp_q   <= lp_d;
      end
    end

    assign long_press = lp_q;
  end else begin : g_no_long
    assign long_press = '0;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (CHANNELS=4, SYNC_STAGES=2,
// STABLE_CYCLES=4, LONG_CYCLES=10). Expected per-edge output vectors are
// built from scheduled event edges and queued, then popped after each edge.
module tb_debounce_bank;

  localparam int unsigned Ch = 4;

  logic          clk;
  logic          rst;
  logic [Ch-1:0] din;
  logic [Ch-1:0] dout;
  logic [Ch-1:0] rise;
  logic [Ch-1:0] fall;
  logic [Ch-1:0] lp;

  typedef struct packed {
    logic [Ch-1:0] o;
    logic [Ch-1:0] r;
    logic [Ch-1:0] f;
    logic [Ch-1:0] l;
  } exp_t;

  exp_t          sb[$];
  logic [Ch-1:0] lvl;
  int            fa[Ch];
  int            fb[Ch];
  int            lpa[Ch];
  int            clr_at;
  int            checks;
  int            errors;

  debounce_bank #(
    .CHANNELS     (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .out       (dout),
    .rise      (rise),
    .fall      (fall),
    .long_press(lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Queue n expected vectors: level flips at fa/fb edges (with pulse),
  // long_press at lpa, silent clear of all levels at clr_at (reset).
  task automatic push_window(input int n);
    exp_t e;
    sb.delete();
    for (int k = 1; k <= n; k++) begin
      e = '0;
      if (k == clr_at) lvl = '0;
      for (int i = 0; i < Ch; i++) begin
        if (k == fa[i] || k == fb[i]) begin
          lvl[i] = ~lvl[i];
          if (lvl[i]) e.r[i] = 1'b1;
          else        e.f[i] = 1'b1;
        end
        if (k == lpa[i]) e.l[i] = 1'b1;
      end
      e.o = lvl;
      sb.push_back(e);
    end
  endtask

  // Reset with all inputs high, release, then a reset mid-hold.
  task automatic test_reset();
    exp_t e;
    fa = '{9, 9, 9, 9}; fb = '{0, 0, 0, 0}; lpa = '{0, 0, 0, 0}; clr_at = 16;
    lvl = '0;
    push_window(30);
    for (int k = 1; k <= 30; k++) begin
      rst = (k <= 3) || (k == 16);
      din = (k < 16) ? 4'hF : 4'h0;
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL reset edge %0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({dout, rise, fall, lp} !== e) begin
          errors++;
          $display("FAIL reset edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                   k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
        end
      end
    end
  endtask

  // Clean step on channel 0 with long press, then release.
  task automatic test_clean_step();
    exp_t e;
    fa = '{6, 0, 0, 0}; fb = '{26, 0, 0, 0}; lpa = '{16, 0, 0, 0}; clr_at = 0;
    push_window(28);
    for (int k = 1; k <= 28; k++) begin
      rst = 1'b0;
      din = (k <= 20) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL clean_step edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  // Bouncing input on channel 1: only the final settled edge counts.
  task automatic test_bounce();
    exp_t e;
    logic [3:0] pat;
    pat = 4'b0101;  // bit k-1 is the value before edge k for k=1..4
    fa = '{0, 10, 0, 0}; fb = '{0, 30, 0, 0}; lpa = '{0, 20, 0, 0}; clr_at = 0;
    push_window(32);
    for (int k = 1; k <= 32; k++) begin
      rst = 1'b0;
      din = '0;
      if (k <= 4)       din[1] = pat[k-1];
      else if (k <= 24) din[1] = 1'b1;
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL bounce edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  // 3-sample low glitch on a settled-high channel 2 never reaches out.
  task automatic test_glitch();
    exp_t e;
    fa = '{0, 0, 6, 0}; fb = '{0, 0, 30, 0}; lpa = '{0, 0, 16, 0}; clr_at = 0;
    push_window(32);
    for (int k = 1; k <= 32; k++) begin
      rst = 1'b0;
      din = '0;
      din[2] = (k <= 9) || (k >= 13 && k <= 24);
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL glitch edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  // Channel 3 held 40 cycles past its rise: exactly one long_press.
  task automatic test_long_press();
    exp_t e;
    fa = '{0, 0, 0, 6}; fb = '{0, 0, 0, 51}; lpa = '{0, 0, 0, 16}; clr_at = 0;
    push_window(54);
    for (int k = 1; k <= 54; k++) begin
      rst = 1'b0;
      din = (k <= 45) ? 4'b1000 : 4'b0000;
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL long_press edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  // Channel 3 high for 8 cycles only: rise and fall, no long_press.
  task automatic test_short_press();
    exp_t e;
    fa = '{0, 0, 0, 6}; fb = '{0, 0, 0, 14}; lpa = '{0, 0, 0, 0}; clr_at = 0;
    push_window(24);
    for (int k = 1; k <= 24; k++) begin
      rst = 1'b0;
      din = (k <= 8) ? 4'b1000 : 4'b0000;
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL short_press edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  // One-cycle reset while channel 0 has counted 2 samples: count restarts.
  task automatic test_reset_mid_count();
    exp_t e;
    fa = '{11, 0, 0, 0}; fb = '{31, 0, 0, 0}; lpa = '{21, 0, 0, 0}; clr_at = 0;
    push_window(34);
    for (int k = 1; k <= 34; k++) begin
      rst = (k == 5);
      din = (k <= 25) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
      checks++;
      e = sb.pop_front();
      if ({dout, rise, fall, lp} !== e) begin
        errors++;
        $display("FAIL reset_mid_count edge %0d: out=%b rise=%b fall=%b lp=%b want %b %b %b %b",
                 k, dout, rise, fall, lp, e.o, e.r, e.f, e.l);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    din    = '0;
    lvl    = '0;
    clr_at = 0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_long_press();
    test_short_press();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
